// File: rtl/ysyx_22041211_lsu.sv
// ysyx_22041211_lsu: load/store unit with an IDLE -> REQ -> DONE handshake to a word-wide memory port.
// Optional macro YSYX_22041211_LSU_MISALIGN_EN traps misaligned halfword/word accesses with err.
module ysyx_22041211_lsu #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] addr,
    input  logic [DATA_LEN-1:0] wdata,
    input  logic [3:0]          lsu_op,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic [3:0]          mem_wmask,
    input  logic                mem_ack,
    input  logic [DATA_LEN-1:0] mem_rdata,
    output logic                out_valid,
    output logic [DATA_LEN-1:0] rdata,
    output logic                err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [DATA_LEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]          op_q, op_d;
    logic                err_q, err_d;
    logic                legal, misalign;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [DATA_LEN-1:0] ld_data;

    // Classify the op being offered: legal encodings and (optionally) alignment faults.
    always_comb begin
        legal = lsu_op[3] ? (lsu_op[2:0] < 3'd3) : (lsu_op[1:0] != 2'b11 && lsu_op[2:0] != 3'b110);
`ifdef YSYX_22041211_LSU_MISALIGN_EN
        misalign = (lsu_op[1:0] == 2'b01 && addr[0]) || (lsu_op[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
    end

    // Lane placement for stores and lane selection plus extension for loads, from the held op.
    always_comb begin
        mem_wmask = !op_q[3] ? 4'b0000 :
                    op_q[1]  ? 4'b1111 :
                    op_q[0]  ? (addr_q[1] ? 4'b1100 : 4'b0011) :
                               4'b0001 << addr_q[1:0];
        mem_wdata = op_q[1] ? wdata_q : op_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
        ld_byte   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data   = op_q[1] ? mem_rdata :
                    op_q[0] ? {{16{~op_q[2] & ld_half[15]}}, ld_half} :
                              {{24{~op_q[2] & ld_byte[7]}}, ld_byte};
    end

    // Next-state: accept in IDLE, wait for the ack in REQ, pulse completion in DONE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        if (state_q == IDLE && in_valid) begin
            addr_d  = addr;
            wdata_d = wdata;
            op_d    = lsu_op;
            err_d   = !legal || misalign;
            rdata_d = '0;
            state_d = (legal && !misalign) ? REQ : DONE;
        end else if (state_q == REQ && mem_ack) begin
            rdata_d = op_q[3] ? '0 : ld_data;
            state_d = DONE;
        end else if (state_q == DONE) begin
            err_d   = 1'b0;
            rdata_d = '0;
            state_d = IDLE;
        end
    end

    // State and operand registers; reset wins over any ack seen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign mem_req   = state_q == REQ;
    assign mem_we    = mem_req & op_q[3];
    assign mem_addr  = {addr_q[DATA_LEN-1:2], 2'b00};
    assign out_valid = state_q == DONE;
    assign err       = err_q;
    assign rdata     = rdata_q;
endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// tb_ysyx_22041211_lsu: randomized scoreboard bench for the LSU against a byte-lane reference model.
module tb_ysyx_22041211_lsu;
    logic        clk = 0, rst = 1, in_valid = 0, mem_ack = 0;
    logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
    logic [3:0]  lsu_op = 0;
    logic        in_ready, mem_req, mem_we, out_valid, err;
    logic [31:0] mem_addr, mem_wdata, rdata;
    logic [3:0]  mem_wmask;

    ysyx_22041211_lsu #(.DATA_LEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .addr(addr), .wdata(wdata),
        .lsu_op(lsu_op), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          e;
        bit          we;
        logic [31:0] res;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [3:0]  mask;
    } exp_t;

    exp_t        req_q[$];
    exp_t        exp_q[$];
    int          vecs = 0, miss = 0;
    logic [31:0] last_rdata, last_wdata, last_addr;
    logic [3:0]  last_wmask;
    logic        last_err;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vecs++;
        if (a !== e) begin
            miss++;
            $display("FAIL %s got=%h want=%h at %0t", n, a, e, $time);
        end
    endtask

    // Reference: an access of n bytes lands at the n-aligned offset inside the word.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                   input logic [3:0] op);
        exp_t   r;
        int     n, off;
        longint v;
        bit     legal;
        n = 1 << op[1:0];
        legal = op[3] ? (op[2:0] inside {3'd0, 3'd1, 3'd2}) : (op[2:0] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        r.e = !legal;
`ifdef YSYX_22041211_LSU_MISALIGN_EN
        if (legal && (int'(a[1:0]) % n) != 0) r.e = 1;
`endif
        off = (int'(a[1:0]) / n) * n;
        r.we = op[3];
        r.maddr = {a[31:2], 2'b00};
        r.mask = 0;
        r.mwd = wd;
        r.res = 0;
        if (op[3] && !r.e) begin
            r.mask = 4'(((1 << n) - 1) << off);
            for (int i = 0; i < 4; i++) r.mwd[8*i +: 8] = wd[8*(i % n) +: 8];
        end else if (!r.e) begin
            v = longint'(rd >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
            if (!op[2] && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
            r.res = v[31:0];
        end
        return r;
    endfunction

    // Monitor: compare every presented request and every completion against the queues.
    always @(negedge clk) begin
        if (mem_req) begin
            if (req_q.size() == 0) chk("unexpected_req", 32'(mem_req), 0);
            else begin
                chk("req_we", 32'(mem_we), 32'(req_q[0].we));
                chk("req_addr", mem_addr, req_q[0].maddr);
                chk("req_wmask", 32'(mem_wmask), 32'(req_q[0].mask));
                if (req_q[0].we) chk("req_wdata", mem_wdata, req_q[0].mwd);
                chk("busy_in_ready", 32'(in_ready), 0);
                last_wmask = mem_wmask;
                last_wdata = mem_wdata;
                last_addr = mem_addr;
                if (mem_ack) void'(req_q.pop_front());
            end
        end
        if (out_valid) begin
            if (exp_q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 0);
            else begin
                chk("done_err", 32'(err), 32'(exp_q[0].e));
                chk("done_rdata", rdata, exp_q[0].res);
                chk("done_in_ready", 32'(in_ready), 0);
                last_rdata = rdata;
                last_err = err;
                void'(exp_q.pop_front());
            end
        end
    end

    // Issue one op from an idle DUT, ack after dly cycles, and check completion latency.
    task automatic do_op(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] op,
                         input logic [31:0] rd, input int dly);
        exp_t m;
        int   lat;
        m = model(a, wd, rd, op);
        exp_q.push_back(m);
        if (!m.e) req_q.push_back(m);
        in_valid = 1;
        addr = a;
        wdata = wd;
        lsu_op = op;
        mem_rdata = rd;
        lat = -1;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            mem_ack = !m.e && (c == dly + 1);
            @(negedge clk);
            if (out_valid) lat = c;
            @(posedge clk);
            #1;
            if (c == 0) begin
                in_valid = 0;
                addr = $urandom;
                wdata = $urandom;
                lsu_op = 4'($urandom);
            end
        end
        mem_ack = 0;
        chk("latency", 32'(lat), m.e ? 1 : 32'(dly + 2));
    endtask

    initial begin
        logic [3:0] op;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rdata", rdata, 0);
        @(posedge clk);
        #1;

        do_op(32'h80000004, 32'hDEADBEEF, 4'b1010, 0, 0);
        chk("sw_wmask", 32'(last_wmask), 32'hF);
        chk("sw_wdata", last_wdata, 32'hDEADBEEF);
        chk("sw_addr", last_addr, 32'h80000004);
        chk("sw_rdata", last_rdata, 0);
        do_op(32'h80000003, 0, 4'b0000, 32'h80FF7F01, 0);
        chk("lb", last_rdata, 32'hFFFFFF80);
        do_op(32'h80000003, 0, 4'b0100, 32'h80FF7F01, 1);
        chk("lbu", last_rdata, 32'h00000080);
        do_op(32'h80000002, 32'h0000ABCD, 4'b1001, 0, 0);
        chk("sh_wmask", 32'(last_wmask), 32'hC);
        chk("sh_wdata", last_wdata, 32'hABCDABCD);
        do_op(32'h80000008, 0, 4'b0010, 32'h13579BDF, 5);
        chk("lw_slow", last_rdata, 32'h13579BDF);
        do_op(32'h80000000, 0, 4'b0011, 0, 0);
        chk("illegal_err", 32'(last_err), 1);
        do_op(32'h80000002, 0, 4'b0010, 32'h2468ACE0, 0);
`ifdef YSYX_22041211_LSU_MISALIGN_EN
        chk("lw_misalign_err", 32'(last_err), 1);
`else
        chk("lw_misalign_err", 32'(last_err), 0);
        chk("lw_misalign_addr", last_addr, 32'h80000000);
`endif

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 4) != 0) begin
                op[3] = 1'($urandom);
                op[2:0] = op[3] ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
                if (op[2:0] == 3'd3) op[2:0] = 3'd5;
            end else op = 4'($urandom);
            do_op($urandom, $urandom, op, $urandom, $urandom_range(0, 4));
        end

        exp_q.push_back(model(32'h80000010, 0, 32'h12345678, 4'b0010));
        req_q.push_back(model(32'h80000010, 0, 32'h12345678, 4'b0010));
        in_valid = 1;
        addr = 32'h80000010;
        lsu_op = 4'b0010;
        @(posedge clk);
        #1;
        in_valid = 0;
        rst = 1;
        mem_ack = 1;
        @(posedge clk);
        #1;
        rst = 0;
        mem_ack = 0;
        @(negedge clk);
        chk("rst_req_drop", 32'(mem_req), 0);
        chk("rst_req_ready", 32'(in_ready), 1);
        chk("rst_req_no_valid", 32'(out_valid), 0);
        void'(exp_q.pop_front());
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_quiet", 32'(out_valid), 0);
        end
        chk("scoreboard_drained", 32'(exp_q.size() + req_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
